// File: rtl/match_pkg.sv
// Shared definitions for the match scorekeeper and the round-arbiter bench:
// scorekeeper state encoding, default match constants and a timer sizing helper.
package match_pkg;

   typedef enum logic [2:0] {
      WAIT    = 3'd0,
      HOLD    = 3'd1,
      CLEAR   = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int SCORE_W_DEF     = 4;
   localparam int WIN_SCORE_DEF   = 5;
   localparam int HOLD_CYCLES_DEF = 50;

   // Counter width for a timer that must hold cycles-1; never narrower than 1 bit.
   function automatic int timer_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/match_scorekeeper_hold_timer.sv
// hold_timer: loadable down-counter used to time the result display window.
// load restarts the count at LOAD_VAL, en counts down, and the count stops at 0.
// zero is high whenever the count is 0.
module hold_timer
   import match_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int LOAD_VAL = 49
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   logic [WIDTH-1:0] count_reg;

   // Load has priority over counting; the count stops at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= LOAD_V;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - ONE;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/match_scorekeeper.sv
// match_scorekeeper: consumes decided rounds from the two-button arbiter,
// keeps both scores, declares the match winner, and holds each result for
// HOLD_CYCLES before pulsing clr to re-arm the arbiter.
// Optional build macro: WIN_BY_TWO_EN enables win-by-two with deuce.
module match_scorekeeper
   import match_pkg::*;
#(
   parameter int SCORE_W     = SCORE_W_DEF,
   parameter int WIN_SCORE   = WIN_SCORE_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               winrnd,
   input  logic               right,
   input  logic               tie,
   output logic               clr,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               match_over,
   output logic               winner_right
);

   localparam int                 TIMER_W = timer_width(HOLD_CYCLES);
   localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] ONE_S   = SCORE_W'(1);

   state_t             state_reg, state_next;
   logic [SCORE_W-1:0] score_l_reg, score_l_next;
   logic [SCORE_W-1:0] score_r_reg, score_r_next;
   logic               winner_right_reg, winner_right_next;

   logic [SCORE_W-1:0] round_l, round_r;
   logic               win_l, win_r;
   logic               timer_load, timer_en, timer_zero;

   hold_timer #(
      .WIDTH    (TIMER_W),
      .LOAD_VAL (HOLD_CYCLES - 1)
   ) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .en   (timer_en),
      .zero (timer_zero)
   );

   // Candidate scores if the round currently presented were scored now.
   always_comb begin
      round_l = score_l_reg;
      round_r = score_r_reg;
      if (!tie) begin
         if (right) begin
            round_r = score_r_reg + ONE_S;
         end else begin
            round_l = score_l_reg + ONE_S;
         end
      end
`ifdef WIN_BY_TWO_EN
      // A point that levels the scores at or above WIN_SCORE drops both to deuce.
      if (!tie && (round_l == round_r) && (round_l >= WIN_S)) begin
         round_l = WIN_S - ONE_S;
         round_r = WIN_S - ONE_S;
      end
`endif
   end

   // Match decision evaluated on the already-updated registered scores.
`ifdef WIN_BY_TWO_EN
   logic [SCORE_W:0] ext_l, ext_r;
   assign ext_l = {1'b0, score_l_reg};
   assign ext_r = {1'b0, score_r_reg};
   assign win_l = (score_l_reg >= WIN_S) && (ext_l >= ext_r + (SCORE_W+1)'(2));
   assign win_r = (score_r_reg >= WIN_S) && (ext_r >= ext_l + (SCORE_W+1)'(2));
`else
   assign win_l = (score_l_reg >= WIN_S);
   assign win_r = (score_r_reg >= WIN_S);
`endif

   // State and score registers; reset returns everything to a fresh match.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= WAIT;
         score_l_reg      <= '0;
         score_r_reg      <= '0;
         winner_right_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         score_l_reg      <= score_l_next;
         score_r_reg      <= score_r_next;
         winner_right_reg <= winner_right_next;
      end
   end

   // Next-state, score update and output decode.
   always_comb begin
      state_next        = state_reg;
      score_l_next      = score_l_reg;
      score_r_next      = score_r_reg;
      winner_right_next = winner_right_reg;
      timer_load        = 1'b0;
      timer_en          = 1'b0;
      clr               = 1'b0;
      match_over        = 1'b0;
      case (state_reg)
         WAIT: begin
            if (winrnd) begin
               state_next   = HOLD;
               score_l_next = round_l;
               score_r_next = round_r;
               timer_load   = 1'b1;
            end
         end
         HOLD: begin
            timer_en = 1'b1;
            if (timer_zero) begin
               if (win_l || win_r) begin
                  state_next        = DONE;
                  winner_right_next = win_r;
               end else begin
                  state_next = CLEAR;
               end
            end
         end
         CLEAR: begin
            clr        = 1'b1;
            state_next = RELEASE;
         end
         RELEASE: begin
            // A round still asserted here was already scored; wait for it to drop.
            if (!winrnd) begin
               state_next = WAIT;
            end
         end
         DONE: begin
            clr        = 1'b1;
            match_over = 1'b1;
         end
         default: begin
            state_next = WAIT;
         end
      endcase
   end

   assign score_l      = score_l_reg;
   assign score_r      = score_r_reg;
   assign winner_right = winner_right_reg;

endmodule

// File: tb/tb_match_scorekeeper.sv
// Testbench for match_scorekeeper with HOLD_CYCLES=4, WIN_SCORE=3.
// Table-driven rounds plus hand-written hold-over and mid-HOLD reset sequences.
// Expectations follow WIN_BY_TWO_EN when the macro is defined.
module tb_match_scorekeeper;

   localparam int SCORE_W     = 4;
   localparam int WIN_SCORE   = 3;
   localparam int HOLD_CYCLES = 4;

   logic               clk;
   logic               rst;
   logic               winrnd;
   logic               right;
   logic               tie;
   logic               clr;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic               match_over;
   logic               winner_right;

   int checks;
   int errors;

   typedef struct {
      logic do_rst;
      logic r;
      logic t;
      int   el;
      int   er;
      logic eo;
      logic ew;
   } vec_t;

   vec_t vecs[$];

   match_scorekeeper #(
      .SCORE_W     (SCORE_W),
      .WIN_SCORE   (WIN_SCORE),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .winrnd       (winrnd),
      .right        (right),
      .tie          (tie),
      .clr          (clr),
      .score_l      (score_l),
      .score_r      (score_r),
      .match_over   (match_over),
      .winner_right (winner_right)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
      @(posedge clk); #1;
      check("rst_clr", int'(clr), 0);
      check("rst_score_l", int'(score_l), 0);
      check("rst_score_r", int'(score_r), 0);
      check("rst_match_over", int'(match_over), 0);
      check("rst_winner_right", int'(winner_right), 0);
      $display("reset applied: clr=%0d l=%0d r=%0d over=%0d wr=%0d",
               clr, score_l, score_r, match_over, winner_right);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic play(input logic r, input logic t, input int el, input int er,
                       input logic eo, input logic ew);
      int n;
      @(negedge clk);
      winrnd = 1'b1; right = r; tie = t;
      @(posedge clk); #1;
      check("score_l", int'(score_l), el);
      check("score_r", int'(score_r), er);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!clr && n < 20);
      check("clr_latency", n, HOLD_CYCLES);
      check("match_over", int'(match_over), int'(eo));
      if (eo) begin
         check("winner_right", int'(winner_right), int'(ew));
         // Further rounds in DONE must be ignored and clr stays high.
         @(negedge clk);
         winrnd = 1'b0;
         @(negedge clk);
         winrnd = 1'b1; right = ~r; tie = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("done_score_l", int'(score_l), el);
            check("done_score_r", int'(score_r), er);
            check("done_clr", int'(clr), 1);
         end
      end else begin
         @(posedge clk); #1;
         check("clr_pulse_width", int'(clr), 0);
      end
      $display("round r=%0d t=%0d: l=%0d r=%0d clr_lat=%0d over=%0d wr=%0d",
               r, t, score_l, score_r, n, match_over, winner_right);
      @(negedge clk);
      winrnd = 1'b0; right = 1'b0; tie = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      rst = 1'b1; winrnd = 1'b0; right = 1'b0; tie = 1'b0;

      // Reset state
      @(posedge clk); #1;
      check("init_clr", int'(clr), 0);
      check("init_score_l", int'(score_l), 0);
      check("init_score_r", int'(score_r), 0);
      check("init_match_over", int'(match_over), 0);
      check("init_winner_right", int'(winner_right), 0);

      // {do_rst, right, tie, exp_l, exp_r, exp_over, exp_winner_right}
      vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0}); // right win
      vecs.push_back('{1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0}); // tie overrides right
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3, 1, 1'b1, 1'b0}); // left takes match
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0});
`ifdef WIN_BY_TWO_EN
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2, 3, 1'b0, 1'b0}); // advantage right
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0}); // back to deuce
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2, 3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2, 4, 1'b1, 1'b1}); // right wins by two
`else
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2, 3, 1'b1, 1'b1}); // first to 3 wins
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_rst) apply_reset();
         play(vecs[i].r, vecs[i].t, vecs[i].el, vecs[i].er, vecs[i].eo, vecs[i].ew);
      end

      // Hold-over: winrnd stays high long after clr; only one point scored.
      apply_reset();
      @(negedge clk);
      winrnd = 1'b1; right = 1'b0; tie = 1'b0;
      @(posedge clk); #1;
      check("hold_score_l", int'(score_l), 1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!clr && n < 20);
      check("hold_clr_latency", n, HOLD_CYCLES);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         check("holdover_score_l", int'(score_l), 1);
         check("holdover_clr", int'(clr), 0);
      end
      $display("hold-over: l=%0d r=%0d after 20 cycles", score_l, score_r);
      @(negedge clk);
      winrnd = 1'b0;
      @(posedge clk);
      play(1'b0, 1'b0, 2, 0, 1'b0, 1'b0);

      // Reset in the middle of HOLD with score_r=2.
      apply_reset();
      play(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
      @(negedge clk);
      winrnd = 1'b1; right = 1'b1; tie = 1'b0;
      @(posedge clk); #1;
      check("midhold_score_r", int'(score_r), 2);
      @(posedge clk);
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check("post_rst_clr", int'(clr), 0);
         check("post_rst_score_r", int'(score_r), 0);
      end
      $display("mid-HOLD reset: clr=%0d l=%0d r=%0d", clr, score_l, score_r);
      play(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
